d_latch: RTL and testbench



---
 rtl/d_latch_pkg.sv | 21 ++
 rtl/d_latch_cell.sv | 48 ++++
 rtl/d_latch.sv | 41 ++++
 tb/tb_d_latch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/d_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_latch_pkg
// Description : Shared constants for the d_latch storage primitive and its
//               single-bit cell.
// Revision    : 1.0 - initial release
// ============================================================================
package d_latch_pkg;

    // Number of stored bits when the user does not override WIDTH.
    localparam int unsigned D_LATCH_DEFAULT_WIDTH = 1;

    // Per-bit reset level; the default reset word is this bit replicated.
    localparam logic D_LATCH_DEFAULT_RESET_BIT = 1'b0;

    // Default reset word for the default width.
    localparam logic [D_LATCH_DEFAULT_WIDTH-1:0] D_LATCH_DEFAULT_RESET =
        {D_LATCH_DEFAULT_WIDTH{D_LATCH_DEFAULT_RESET_BIT}};

endpackage : d_latch_pkg
`default_nettype wire

// File: rtl/d_latch_cell.sv
`default_nettype none
// ============================================================================
// Module      : d_latch_cell
// Description : One bit of level-enabled storage built from a plain
//               edge-triggered flop. While en is high the bit follows d with
//               one clock of latency; while en is low it holds. nq is the
//               complement of the same flop, never stored separately.
// Revision    : 1.0 - initial release
// ============================================================================
module d_latch_cell
    import d_latch_pkg::*;
#(
    parameter logic RESET_BIT = D_LATCH_DEFAULT_RESET_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic en,
    output logic q,
    output logic nq
);

    logic r_bit_q;
    logic w_bit_d;

    // Next value: capture d while enabled, otherwise hold the stored bit.
    always_comb begin
        w_bit_d = r_bit_q;
        if (en) begin
            w_bit_d = d;
        end
    end

    // Storage flop; reset wins over the enable at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_q <= RESET_BIT;
        end else begin
            r_bit_q <= w_bit_d;
        end
    end

    // Both outputs come from the one flop so they can never disagree.
    assign q  = r_bit_q;
    assign nq = ~r_bit_q;

endmodule : d_latch_cell
`default_nettype wire

// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
// Module      : d_latch
// Description : WIDTH-bit level-enabled D storage element realised as
//               synchronous registers, so no real latch is inferred. C is a
//               shared enable sampled at each rising clk; Q updates one
//               cycle after capture and NQ is always its bitwise complement.
// Revision    : 1.0 - initial release
// ============================================================================
module d_latch
    import d_latch_pkg::*;
#(
    parameter int unsigned          WIDTH       = D_LATCH_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{D_LATCH_DEFAULT_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] NQ,
    input  logic [WIDTH-1:0] D,
    input  logic             C
);

    // One independent cell per bit, all sharing the same enable.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
            d_latch_cell #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .d   (D[gi]),
                .en  (C),
                .q   (Q[gi]),
                .nq  (NQ[gi])
            );
        end
    endgenerate

endmodule : d_latch
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_latch
// Description : Self-checking bench for d_latch. Drives a default 1-bit
//               instance and an 8-bit instance with reset value A5 against a
//               behavioural "last captured value" reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic       c1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] nq1;
    logic       c8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] nq8;

    int tests = 0;
    int fails = 0;

    // Reference model: the value most recently stored by each instance.
    logic [0:0] exp1;
    logic [7:0] exp8;

    always #5 clk = ~clk;

    d_latch u_dut1 (
        .clk (clk),
        .rst (rst),
        .Q   (q1),
        .NQ  (nq1),
        .D   (d1),
        .C   (c1)
    );

    d_latch #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .Q   (q8),
        .NQ  (nq8),
        .D   (d8),
        .C   (c8)
    );

    // Apply one cycle of inputs, pass the rising edge, update the model.
    task automatic step(input logic r, input logic ca, input logic [0:0] da,
                        input logic cb, input logic [7:0] db);
        rst = r;
        c1  = ca;
        d1  = da;
        c8  = cb;
        d8  = db;
        @(posedge clk);
        #1;
        if (r) begin
            exp1 = 1'b0;
            exp8 = 8'hA5;
        end else begin
            if (ca) exp1 = da;
            if (cb) exp8 = db;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
            tests++;
            if (q1 !== 1'b0 || nq1 !== 1'b1) begin
                fails++;
                $display("FAIL reset_w1 cyc%0d: Q=%b NQ=%b expected Q=0 NQ=1", i, q1, nq1);
            end
            tests++;
            if (q8 !== 8'hA5 || nq8 !== 8'h5A) begin
                fails++;
                $display("FAIL reset_w8 cyc%0d: Q=%h NQ=%h expected Q=a5 NQ=5a", i, q8, nq8);
            end
        end
        // Release with enable low so the reset value persists.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
        tests++;
        if (q1 !== 1'b0 || nq1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: Q=%b NQ=%b expected Q=0 NQ=1", q1, nq1);
        end
    endtask

    task automatic test_hold();
        logic [0:0] pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b0, pat[p], 1'b0, 8'(($urandom)));
                tests++;
                if (q1 !== 1'b0 || nq1 !== 1'b1) begin
                    fails++;
                    $display("FAIL hold_disabled p%0d k%0d: Q=%b NQ=%b expected Q=0 NQ=1", p, k, q1, nq1);
                end
            end
        end
        tests++;
        if (q8 !== 8'hA5) begin
            fails++;
            $display("FAIL hold_disabled_w8: Q=%h expected a5", q8);
        end
    endtask

    task automatic test_capture();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tests++;
        if (q1 !== 1'b0) begin
            fails++;
            $display("FAIL capture_pre: Q=%b expected 0", q1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tests++;
        if (q1 !== 1'b1 || nq1 !== 1'b0) begin
            fails++;
            $display("FAIL capture: Q=%b NQ=%b expected Q=1 NQ=0", q1, nq1);
        end
    endtask

    task automatic test_close_hold();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tests++;
        if (q1 !== 1'b1 || nq1 !== 1'b0) begin
            fails++;
            $display("FAIL close_hold: Q=%b NQ=%b expected Q=1 NQ=0", q1, nq1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tests++;
        if (q1 !== 1'b0 || nq1 !== 1'b1) begin
            fails++;
            $display("FAIL reopen: Q=%b NQ=%b expected Q=0 NQ=1", q1, nq1);
        end
    endtask

    // C held high: Q must equal the D applied one edge earlier, except the
    // edge where reset is asserted.
    task automatic test_tracking();
        logic [0:0] dv;
        logic       r;
        logic [0:0] want;
        for (int i = 0; i < 24; i++) begin
            dv   = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (i > 12) dv = 1'(($urandom));
            r    = (i == 10);
            want = r ? 1'b0 : dv;
            step(r, 1'b1, dv, 1'b0, 8'h00);
            tests++;
            if (q1 !== want || nq1 !== ~want) begin
                fails++;
                $display("FAIL tracking i%0d rst=%b: Q=%b NQ=%b expected Q=%b", i, r, q1, nq1, want);
            end
        end
    endtask

    task automatic test_width8();
        logic       cb;
        logic [7:0] db;
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        tests++;
        if (q8 !== 8'hA5 || nq8 !== 8'h5A) begin
            fails++;
            $display("FAIL w8_reset: Q=%h NQ=%h expected Q=a5 NQ=5a", q8, nq8);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
        tests++;
        if (q8 !== 8'h3C || nq8 !== 8'hC3) begin
            fails++;
            $display("FAIL w8_capture: Q=%h NQ=%h expected Q=3c NQ=c3", q8, nq8);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
            tests++;
            if (q8 !== 8'h3C || (q8 ^ nq8) !== 8'hFF) begin
                fails++;
                $display("FAIL w8_hold k%0d: Q=%h NQ=%h expected Q=3c NQ=c3", k, q8, nq8);
            end
        end
        // Random enable/data, occasional reset, checked against the model.
        for (int k = 0; k < 40; k++) begin
            cb = 1'(($urandom));
            db = 8'(($urandom));
            step(($urandom_range(0, 15) == 0), 1'b0, 1'b0, cb, db);
            tests++;
            if (q8 !== exp8 || (q8 ^ nq8) !== 8'hFF) begin
                fails++;
                $display("FAIL w8_random k%0d: Q=%h NQ=%h expected Q=%h", k, q8, nq8, exp8);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        c1  = 1'b0;
        d1  = 1'b0;
        c8  = 1'b0;
        d8  = 8'h00;
        test_reset();
        test_hold();
        test_capture();
        test_close_hold();
        test_tracking();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_d_latch
`default_nettype wire
